// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiply / restoring divide unit with HI/LO result
// Signed MULT/DIV support is built only when MDU_SIGNED_EN is defined; otherwise all ops are unsigned.
module mult_div_unit #(
   parameter int N     = 32,
   parameter int CNT_W = $clog2(N) + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [N-1:0] rs_data_i,
   input  logic [N-1:0] rt_data_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         div_by_zero_o,
   output logic [N-1:0] hi_o,
   output logic [N-1:0] lo_o
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [N-1:0]     w_hi_q, w_hi_d;
   logic [N-1:0]     w_lo_q, w_lo_d;
   logic [N-1:0]     hi_q, hi_d;
   logic [N-1:0]     lo_q, lo_d;
   logic             dbz_q, dbz_d;

   logic [2*N-1:0]   prod;
   logic [N-1:0]     quo;
   logic [N-1:0]     rem;
   logic [N-1:0]     raw_a;
   logic [N:0]       add_sum;
   logic [N:0]       shifted;
   logic [N:0]       sub_diff;

`ifdef MDU_SIGNED_EN
   logic             neg_a_q, neg_a_d;
   logic             neg_r_q, neg_r_d;
   logic             neg_b;
`else
   logic             unused_op_signed;
   assign unused_op_signed = op_i[0];
`endif

   // One shift-add step on {w_hi,w_lo}, and one restoring-subtract step on the remainder.
   assign add_sum  = {1'b0, w_hi_q} + (w_lo_q[0] ? {1'b0, a_q} : '0);
   assign shifted  = {w_hi_q, w_lo_q[N-1]};
   assign sub_diff = shifted - {1'b0, b_q};

   assign busy_o        = (state_q == RUN);
   assign done_o        = (state_q == FINISH);
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      a_d     = a_q;
      b_d     = b_q;
      w_hi_d  = w_hi_q;
      w_lo_d  = w_lo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      prod    = {w_hi_q, w_lo_q};
      quo     = w_lo_q;
      rem     = w_hi_q;
      raw_a   = a_q;
`ifdef MDU_SIGNED_EN
      neg_a_d = neg_a_q;
      neg_r_d = neg_r_q;
      neg_b   = 1'b0;
`endif
      case (state_q)
         RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (div_q) begin
                  if (!sub_diff[N]) begin
                     w_hi_d = sub_diff[N-1:0];
                     w_lo_d = {w_lo_q[N-2:0], 1'b1};
                  end else begin
                     w_hi_d = shifted[N-1:0];
                     w_lo_d = {w_lo_q[N-2:0], 1'b0};
                  end
               end else begin
                  w_hi_d = add_sum[N:1];
                  w_lo_d = {add_sum[0], w_lo_q[N-1:1]};
               end
            end else begin
               // Last RUN edge: apply sign correction and publish HI/LO.
`ifdef MDU_SIGNED_EN
               if (neg_r_q) begin
                  prod = -{w_hi_q, w_lo_q};
                  quo  = -w_lo_q;
               end
               if (neg_a_q) begin
                  rem   = -w_hi_q;
                  raw_a = -a_q;
               end
`endif
               if (!div_q) begin
                  hi_d = prod[2*N-1:N];
                  lo_d = prod[N-1:0];
               end else if (b_q == '0) begin
                  hi_d  = raw_a;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem;
                  lo_d = quo;
               end
               state_d = FINISH;
            end
         end
         default: begin
            state_d = IDLE;
            if (start_i) begin
               state_d = RUN;
               cnt_d   = CNT_W'(N);
               div_d   = op_i[1];
               dbz_d   = 1'b0;
`ifdef MDU_SIGNED_EN
               neg_a_d = op_i[0] & rs_data_i[N-1];
               neg_b   = op_i[0] & rt_data_i[N-1];
               neg_r_d = neg_a_d ^ neg_b;
               a_d     = neg_a_d ? -rs_data_i : rs_data_i;
               b_d     = neg_b ? -rt_data_i : rt_data_i;
`else
               a_d     = rs_data_i;
               b_d     = rt_data_i;
`endif
               w_hi_d  = '0;
               w_lo_d  = op_i[1] ? a_d : b_d;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         w_hi_q  <= '0;
         w_lo_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
         neg_a_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         a_q     <= a_d;
         b_q     <= b_d;
         w_hi_q  <= w_hi_d;
         w_lo_q  <= w_lo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
`ifdef MDU_SIGNED_EN
         neg_a_q <= neg_a_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
// Expected values follow the MDU_SIGNED_EN build setting.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic        busy_o;
   logic        done_o;
   logic        div_by_zero_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   mult_div_unit #(.N(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .op_i          (op_i),
      .rs_data_i     (rs_data_i),
      .rt_data_i     (rt_data_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .div_by_zero_o (div_by_zero_o),
      .hi_o          (hi_o),
      .lo_o          (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept edge E0 happens inside; returns at E0+1.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_i   = 1'b1;
      op_i      = op;
      rs_data_i = a;
      rt_data_i = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("busy_at_accept", {31'b0, busy_o}, 32'd1);
   endtask

   // Counts edges after the current point until done_o is seen, bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!done_o && cycles < 100);
   endtask

   task automatic finish_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int c;
      wait_done(c);
      check({tag, "_latency"}, c, 32'd33);
      check({tag, "_hi"}, hi_o, exp_hi);
      check({tag, "_lo"}, lo_o, exp_lo);
   endtask

   initial begin
      reset     = 1'b0;
      start_i   = 1'b0;
      op_i      = 2'b00;
      rs_data_i = '0;
      rt_data_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_dbz", {31'b0, div_by_zero_o}, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      finish_op("multu_max", 32'hFFFFFFFE, 32'h00000001);
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'b0, done_o}, 32'd0);
      check("idle_busy", {31'b0, busy_o}, 32'd0);
      check("hold_lo", lo_o, 32'h00000001);

`ifdef MDU_SIGNED_EN
      issue(2'b01, 32'hFFFFFFFD, 32'd7);
      finish_op("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB);
      issue(2'b11, 32'hFFFFFFF9, 32'd2);
      finish_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
      finish_op("div_minneg", 32'h00000000, 32'h80000000);
`else
      issue(2'b01, 32'hFFFFFFFD, 32'd7);
      finish_op("mult_neg", 32'h00000006, 32'hFFFFFFEB);
      issue(2'b11, 32'hFFFFFFF9, 32'd2);
      finish_op("div_neg", 32'h00000001, 32'h7FFFFFFC);
      issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
      finish_op("div_minneg", 32'h80000000, 32'h00000000);
`endif
      check("minneg_dbz", {31'b0, div_by_zero_o}, 32'd0);

      issue(2'b10, 32'd100, 32'd7);
      finish_op("divu_100_7", 32'd2, 32'd14);

      issue(2'b10, 32'h00001234, 32'd0);
      finish_op("divu_zero", 32'h00001234, 32'hFFFFFFFF);
      check("dbz_set", {31'b0, div_by_zero_o}, 32'd1);
      @(posedge clk);
      #1;
      check("dbz_held", {31'b0, div_by_zero_o}, 32'd1);
      issue(2'b00, 32'd3, 32'd4);
      check("dbz_cleared", {31'b0, div_by_zero_o}, 32'd0);
      finish_op("multu_3_4", 32'd0, 32'd12);

      // Divide by zero returns the raw dividend, even for a negative signed one.
      issue(2'b11, 32'hFFFFFFF0, 32'd0);
      finish_op("div_zero_neg", 32'hFFFFFFF0, 32'hFFFFFFFF);
      check("dbz_signed", {31'b0, div_by_zero_o}, 32'd1);

      issue(2'b00, 32'd5, 32'd6);
      repeat (5) @(posedge clk);
      #1;
      start_i   = 1'b1;
      op_i      = 2'b10;
      rs_data_i = 32'd9;
      rt_data_i = 32'd9;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_done(n);
      check("ignored_latency", n, 32'd27);
      check("ignored_lo", lo_o, 32'd30);
      check("ignored_hi", hi_o, 32'd0);

      @(negedge clk);
      start_i   = 1'b1;
      op_i      = 2'b00;
      rs_data_i = 32'd2;
      rt_data_i = 32'd3;
      @(posedge clk);
      #1;
      check("b2b_first_busy", {31'b0, busy_o}, 32'd1);
      rs_data_i = 32'd7;
      rt_data_i = 32'd8;
      wait_done(n);
      check("b2b_first_latency", n, 32'd33);
      check("b2b_first_lo", lo_o, 32'd6);
      @(posedge clk);
      #1;
      check("b2b_no_gap", {31'b0, busy_o}, 32'd1);
      start_i = 1'b0;
      wait_done(n);
      check("b2b_second_latency", n, 32'd33);
      check("b2b_second_lo", lo_o, 32'd56);

      issue(2'b00, 32'd11, 32'd13);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midrun_rst_busy", {31'b0, busy_o}, 32'd0);
      check("midrun_rst_done", {31'b0, done_o}, 32'd0);
      check("midrun_rst_hi", hi_o, 32'd0);
      check("midrun_rst_lo", lo_o, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      issue(2'b00, 32'd3, 32'd5);
      finish_op("after_rst", 32'd0, 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
